fixed_point_divider: RTL and testbench

Sequential signed fixed-point divider computing out = (a · 2^IN_SCALE) / b, the inverse of the datapath's scaled multiplier (a·b >> OUT_SCALE). It sits beside the multiplier in the accelerator's arithmetic building blocks. It is used wherever a scaled quotient is needed, for example rescaling and normalisation. Operands enter and results leave through valid/ready handshakes, and one quotient bit is resolved per clock using a restoring shift-subtract algorithm.

---
 rtl/fixed_point_divider.sv | 130 +++++++++++++
 tb/tb_fixed_point_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: out = (a << IN_SCALE) / b, truncated toward zero,
// saturated to OUT_WIDTH. Restoring shift-subtract, one quotient bit per clock.
module fixed_point_divider #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int IN_SCALE  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_div_by_zero,
  output logic                 out_saturated
);

  localparam int N  = A_WIDTH + IN_SCALE;
  localparam int CW = $clog2(N + 1);
  localparam int SW = ((N > OUT_WIDTH) ? N : OUT_WIDTH) + 1;

  localparam logic [SW-1:0]        NEG_LIM = SW'(1) << (OUT_WIDTH - 1);
  localparam logic [SW-1:0]        POS_LIM = NEG_LIM - SW'(1);
  localparam logic [OUT_WIDTH-1:0] OMAX    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OMIN    = ~OMAX;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [B_WIDTH:0]   rem;
  logic [N-1:0]       quo;
  logic [N-1:0]       div_sr;
  logic [B_WIDTH:0]   b_abs;
  logic               neg;

  // Magnitudes one bit wider so the most negative operands negate correctly.
  logic [A_WIDTH:0]   a_ext, a_abs;
  logic [B_WIDTH:0]   b_ext, b_in_abs;
  logic [B_WIDTH+1:0] rem_sh, rem_nx;
  logic               ge;
  logic [N-1:0]       quo_nx;
  logic [SW-1:0]      mag, sq;
  logic [OUT_WIDTH-1:0] res;
  logic               sat;

  always_comb begin
    a_ext    = {in_a[A_WIDTH-1], in_a};
    a_abs    = a_ext[A_WIDTH] ? -a_ext : a_ext;
    b_ext    = {in_b[B_WIDTH-1], in_b};
    b_in_abs = b_ext[B_WIDTH] ? -b_ext : b_ext;

    rem_sh = {rem, div_sr[N-1]};
    ge     = rem_sh >= {1'b0, b_abs};
    rem_nx = ge ? (rem_sh - {1'b0, b_abs}) : rem_sh;
    quo_nx = (quo << 1) | N'(ge);

    mag = SW'(quo_nx);
    sq  = neg ? -mag : mag;
    res = OUT_WIDTH'(sq);
    sat = 1'b0;
    if (!neg && (mag > POS_LIM)) begin
      res = OMAX;
      sat = 1'b1;
    end else if (neg && (mag > NEG_LIM)) begin
      res = OMIN;
      sat = 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state           <= IDLE;
      cnt             <= '0;
      rem             <= '0;
      quo             <= '0;
      div_sr          <= '0;
      b_abs           <= '0;
      neg             <= 1'b0;
      out             <= '0;
      out_div_by_zero <= 1'b0;
      out_saturated   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            b_abs  <= b_in_abs;
            neg    <= in_a[A_WIDTH-1] ^ in_b[B_WIDTH-1];
            div_sr <= N'(a_abs) << IN_SCALE;
            rem    <= '0;
            quo    <= '0;
            if (in_b == '0) begin
              out             <= in_a[A_WIDTH-1] ? OMIN : OMAX;
              out_div_by_zero <= 1'b1;
              out_saturated   <= 1'b0;
              state           <= DONE;
            end else begin
              cnt   <= CW'(N);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem    <= (B_WIDTH+1)'(rem_nx);
          quo    <= quo_nx;
          div_sr <= div_sr << 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out             <= res;
            out_div_by_zero <= 1'b0;
            out_saturated   <= sat;
            state           <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Randomized self-checking bench for fixed_point_divider against an arithmetic reference model.
module tb_fixed_point_divider;

  localparam int A_WIDTH   = 16;
  localparam int B_WIDTH   = 16;
  localparam int IN_SCALE  = 16;
  localparam int OUT_WIDTH = 32;
  localparam int N         = A_WIDTH + IN_SCALE;

  logic                 clk = 1'b0;
  logic                 arst_n_in;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_div_by_zero;
  logic                 out_saturated;

  int checks = 0;
  int errors = 0;

  fixed_point_divider #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .IN_SCALE(IN_SCALE), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_div_by_zero(out_div_by_zero), .out_saturated(out_saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input longint a, input longint b,
                                output longint q, output bit dz, output bit sat);
    longint maxv, minv, full;
    maxv = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
    minv = -(longint'(1) <<< (OUT_WIDTH - 1));
    dz = 1'b0;
    sat = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q  = (a < 0) ? minv : maxv;
    end else begin
      full = (a * (longint'(1) <<< IN_SCALE)) / b;
      if (full > maxv) begin
        q = maxv; sat = 1'b1;
      end else if (full < minv) begin
        q = minv; sat = 1'b1;
      end else begin
        q = full;
      end
    end
  endfunction

  function automatic longint sout();
    return longint'($signed(out));
  endfunction

  task automatic run_op(input longint a, input longint b, input int hold);
    longint q, snap;
    bit dz, sat;
    int edges;
    @(negedge clk);
    in_a      = A_WIDTH'(a);
    in_b      = B_WIDTH'(b);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    model(a, b, q, dz, sat);
    chk("latency", edges + 1, (b == 0) ? 1 : N + 1);
    chk("out", sout(), q);
    chk("div_by_zero", longint'(out_div_by_zero), longint'(dz));
    chk("saturated", longint'(out_saturated), longint'(sat));
    chk("in_ready_busy", longint'(in_ready), 0);
    snap = sout();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_a     = A_WIDTH'($urandom);
      in_b     = B_WIDTH'($urandom);
      @(posedge clk); #1;
      chk("hold_out", sout(), snap);
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_in_ready", longint'(in_ready), 0);
      chk("hold_dz", longint'(out_div_by_zero), longint'(dz));
    end
    if (hold > 0) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("consumed_valid", longint'(out_valid), 0);
    chk("consumed_in_ready", longint'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [A_WIDTH-1:0] ra;
    logic [B_WIDTH-1:0] rb;
    longint a, b;
    int stray;
    arst_n_in = 1'b0;
    in_a = '0; in_b = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out", sout(), 0);
    chk("rst_flags", longint'({out_div_by_zero, out_saturated}), 0);
    @(negedge clk);
    arst_n_in = 1'b1;

    run_op(3, 2, 0);
    run_op(-1, 3, 0);
    run_op(-7, 2, 2);
    run_op(0, -5, 0);
    run_op(5, 0, 0);
    run_op(-5, 0, 1);
    run_op(-32768, -1, 0);
    run_op(-32768, 1, 0);
    run_op(-32768, -32768, 0);
    run_op(32767, 1, 0);
    run_op(1, -32768, 0);
    run_op(3, 2, 10);

    // Abort mid-calculation with an asynchronous reset.
    run_op(-7, 3, 0);
    @(negedge clk);
    in_a = 16'd3; in_b = 16'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    arst_n_in = 1'b0;
    #1;
    chk("abort_out", sout(), 0);
    chk("abort_valid", longint'(out_valid), 0);
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_flags", longint'({out_div_by_zero, out_saturated}), 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) stray++;
    end
    chk("abort_no_result", stray, 0);
    run_op(3, 2, 0);

    for (int k = 0; k < 30; k++) begin
      ra = A_WIDTH'($urandom);
      rb = B_WIDTH'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: ra = {1'b1, {(A_WIDTH-1){1'b0}}};
        2: rb = B_WIDTH'($urandom_range(1, 4));
        3: rb = '1;
        default: ;
      endcase
      a = longint'($signed(ra));
      b = longint'($signed(rb));
      run_op(a, b, $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
